// File: rtl/store_checker.sv
// Data-memory store monitor: replays a preloaded list of expected stores against
// the core's write port and settles on a sticky PASS/FAIL verdict.
module store_checker #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CW      = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          exp_valid,
    input  logic [31:0]   exp_adr,
    input  logic [31:0]   exp_data,
    output logic          exp_full,
    input  logic          arm,
    input  logic          MemWrite,
    input  logic [31:0]   DataAdr,
    input  logic [31:0]   WriteData,
    output logic [1:0]    state,
    output logic          done,
    output logic          pass,
    output logic          timed_out,
    output logic [31:0]   fail_adr,
    output logic [31:0]   fail_data,
    output logic [CW-1:0] match_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NW = PW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t          state_q;
    logic [31:0]     adr_mem_q  [DEPTH];
    logic [31:0]     data_mem_q [DEPTH];
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [NW-1:0]   count_q;
    logic [TW-1:0]   timer_q;
    logic [CW-1:0]   match_count_q;
    logic            timed_out_q;
    logic [31:0]     fail_adr_q;
    logic [31:0]     fail_data_q;

    logic            push_ok;
    logic            store_hit;
    logic            last_entry;
    logic            timer_expire;
    logic [TW-1:0]   timer_d;

    always_comb begin
        push_ok      = exp_valid && (count_q != NW'(DEPTH));
        store_hit    = (DataAdr == adr_mem_q[head_q]) && (WriteData == data_mem_q[head_q]);
        last_entry   = (count_q == NW'(1));
        timer_d      = timer_q + TW'(1);
        timer_expire = (timer_d == TW'(TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            timer_q       <= '0;
            match_count_q <= '0;
            timed_out_q   <= 1'b0;
            fail_adr_q    <= '0;
            fail_data_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (push_ok) begin
                        adr_mem_q[tail_q]  <= exp_adr;
                        data_mem_q[tail_q] <= exp_data;
                        tail_q             <= tail_q + PW'(1);
                    end
                    count_q <= count_q + NW'(push_ok);
                    // A push in the arming cycle already counts towards a non-empty list
                    if (arm) begin
                        timer_q <= '0;
                        state_q <= ((count_q != '0) || push_ok) ? S_RUN : S_PASS;
                    end
                end
                S_RUN: begin
                    if (MemWrite) begin
                        if (store_hit) begin
                            head_q  <= head_q + PW'(1);
                            count_q <= count_q - NW'(1);
                            timer_q <= '0;
                            if (!(&match_count_q)) begin
                                match_count_q <= match_count_q + CW'(1);
                            end
                            if (last_entry) begin
                                state_q <= S_PASS;
                            end
                        end else begin
                            state_q     <= S_FAIL;
                            fail_adr_q  <= DataAdr;
                            fail_data_q <= WriteData;
                        end
                    end else begin
                        timer_q <= timer_d;
                        if (timer_expire) begin
                            state_q     <= S_FAIL;
                            timed_out_q <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state       = state_q;
        done        = (state_q == S_PASS) || (state_q == S_FAIL);
        pass        = (state_q == S_PASS);
        exp_full    = (count_q == NW'(DEPTH));
        timed_out   = timed_out_q;
        fail_adr    = fail_adr_q;
        fail_data   = fail_data_q;
        match_count = match_count_q;
    end

endmodule

// File: tb/tb_store_checker.sv
// Bench for store_checker: directed store sequences, a queue-based reference of the
// expected-store list checked every cycle, plus literal spot checks.
module tb_store_checker;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned CW      = 4;
    localparam int unsigned TIMEOUT = 64;

    logic          clk;
    logic          reset;
    logic          exp_valid;
    logic [31:0]   exp_adr;
    logic [31:0]   exp_data;
    logic          exp_full;
    logic          arm;
    logic          MemWrite;
    logic [31:0]   DataAdr;
    logic [31:0]   WriteData;
    logic [1:0]    state;
    logic          done;
    logic          pass;
    logic          timed_out;
    logic [31:0]   fail_adr;
    logic [31:0]   fail_data;
    logic [CW-1:0] match_count;

    store_checker #(
        .DEPTH   (DEPTH),
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .exp_valid   (exp_valid),
        .exp_adr     (exp_adr),
        .exp_data    (exp_data),
        .exp_full    (exp_full),
        .arm         (arm),
        .MemWrite    (MemWrite),
        .DataAdr     (DataAdr),
        .WriteData   (WriteData),
        .state       (state),
        .done        (done),
        .pass        (pass),
        .timed_out   (timed_out),
        .fail_adr    (fail_adr),
        .fail_data   (fail_data),
        .match_count (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic        cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: list of pending expected stores, verdict and counters
    logic [63:0]  mq[$];
    int unsigned  m_st   = 0;   // 0 idle, 1 checking, 2 pass, 3 fail
    int unsigned  m_cnt  = 0;
    int unsigned  m_sil  = 0;
    int unsigned  m_to   = 0;
    logic [31:0]  m_fa   = '0;
    logic [31:0]  m_fd   = '0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_st = 0; m_cnt = 0; m_sil = 0; m_to = 0; m_fa = '0; m_fd = '0;
        end else if (m_st == 0) begin
            if (exp_valid && mq.size() < DEPTH) mq.push_back({exp_adr, exp_data});
            if (arm) begin
                m_sil = 0;
                m_st  = (mq.size() > 0) ? 1 : 2;
            end
        end else if (m_st == 1) begin
            if (MemWrite) begin
                if ({DataAdr, WriteData} == mq[0]) begin
                    void'(mq.pop_front());
                    if (m_cnt < (1 << CW) - 1) m_cnt++;
                    m_sil = 0;
                    if (mq.size() == 0) m_st = 2;
                end else begin
                    m_st = 3; m_fa = DataAdr; m_fd = WriteData;
                end
            end else begin
                m_sil++;
                if (m_sil == TIMEOUT) begin
                    m_st = 3; m_to = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("state",       32'(state),       m_st);
            chk("done",        32'(done),        32'(m_st >= 2));
            chk("pass",        32'(pass),        32'(m_st == 2));
            chk("exp_full",    32'(exp_full),    32'(mq.size() == DEPTH));
            chk("timed_out",   32'(timed_out),   m_to);
            chk("fail_adr",    fail_adr,         m_fa);
            chk("fail_data",   fail_data,        m_fd);
            chk("match_count", 32'(match_count), m_cnt);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        cmp_en = 1'b1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_mc",    32'(match_count), 32'd0);
        chk("rst_full",  32'(exp_full), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        reset = 1'b0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        exp_valid = 1'b1; exp_adr = a; exp_data = d;
        step();
        exp_valid = 1'b0;
    endtask

    task automatic arm_it();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1; DataAdr = a; WriteData = d;
        step();
        MemWrite = 1'b0;
    endtask

    initial begin
        reset = 1'b0; exp_valid = 1'b0; exp_adr = '0; exp_data = '0;
        arm = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
        step();

        // Single store after idle cycles; a store before arming is ignored
        do_reset();
        push(32'h64, 32'd7);
        store(32'h64, 32'd9);
        chk("t1_idle_state", 32'(state), 32'd0);
        arm_it();
        repeat (3) step();
        store(32'h64, 32'd7);
        chk("t1_state", 32'(state), 32'd2);
        chk("t1_pass",  32'(pass), 32'd1);
        chk("t1_mc",    32'(match_count), 32'd1);
        chk("t1_to",    32'(timed_out), 32'd0);

        // Three stores in order
        do_reset();
        push(32'h60, 32'd3); push(32'h64, 32'd7); push(32'h68, 32'd9);
        arm_it();
        store(32'h60, 32'd3);
        chk("t2_run1", 32'(state), 32'd1);
        store(32'h64, 32'd7);
        chk("t2_run2", 32'(state), 32'd1);
        push(32'h70, 32'd1);
        store(32'h68, 32'd9);
        chk("t2_state", 32'(state), 32'd2);
        chk("t2_mc",    32'(match_count), 32'd3);

        // Data mismatch, verdict held despite later activity
        do_reset();
        push(32'h64, 32'd7);
        arm_it();
        store(32'h64, 32'd8);
        chk("t3_state", 32'(state), 32'd3);
        chk("t3_fa",    fail_adr, 32'h64);
        chk("t3_fd",    fail_data, 32'd8);
        chk("t3_mc",    32'(match_count), 32'd0);
        chk("t3_to",    32'(timed_out), 32'd0);
        repeat (10) step();
        store(32'h64, 32'd7);
        arm_it();
        repeat (8) step();
        chk("t3_hold",  32'(state), 32'd3);
        chk("t3_fa2",   fail_adr, 32'h64);

        // Timeout after exactly TIMEOUT silent cycles
        do_reset();
        push(32'h80, 32'h55);
        arm_it();
        repeat (TIMEOUT - 1) step();
        chk("t4_edge_run", 32'(state), 32'd1);
        step();
        chk("t4_state", 32'(state), 32'd3);
        chk("t4_to",    32'(timed_out), 32'd1);
        chk("t4_fa",    fail_adr, 32'd0);

        // Store on the last allowed cycle is still compared
        do_reset();
        push(32'h80, 32'h55);
        arm_it();
        repeat (TIMEOUT - 1) step();
        store(32'h80, 32'h55);
        chk("t4b_state", 32'(state), 32'd2);
        chk("t4b_to",    32'(timed_out), 32'd0);

        // Full queue, dropped ninth push
        do_reset();
        for (int i = 0; i < 9; i++) begin
            push(32'h100 + 32'(4 * i), 32'(3 * i + 1));
            if (i == 6) chk("t5_not_full", 32'(exp_full), 32'd0);
            if (i == 7) chk("t5_full",     32'(exp_full), 32'd1);
        end
        chk("t5_full9", 32'(exp_full), 32'd1);
        arm_it();
        for (int i = 0; i < 8; i++) store(32'h100 + 32'(4 * i), 32'(3 * i + 1));
        chk("t5_state", 32'(state), 32'd2);
        chk("t5_mc",    32'(match_count), 32'd8);

        // Arm with an empty list
        do_reset();
        arm_it();
        chk("t5b_state", 32'(state), 32'd2);

        // Push and arm on the same edge
        do_reset();
        exp_valid = 1'b1; exp_adr = 32'h20; exp_data = 32'hABCD; arm = 1'b1;
        step();
        exp_valid = 1'b0; arm = 1'b0;
        chk("t7_state", 32'(state), 32'd1);
        store(32'h20, 32'hABCD);
        chk("t7_pass",  32'(state), 32'd2);

        // Reset mid-run, then a clean rerun
        do_reset();
        push(32'h60, 32'd3); push(32'h64, 32'd7); push(32'h68, 32'd9);
        arm_it();
        store(32'h60, 32'd3);
        chk("t6_mc1", 32'(match_count), 32'd1);
        do_reset();
        push(32'h60, 32'd3); push(32'h64, 32'd7); push(32'h68, 32'd9);
        arm_it();
        store(32'h60, 32'd3); store(32'h64, 32'd7); store(32'h68, 32'd9);
        chk("t6_state", 32'(state), 32'd2);
        chk("t6_mc",    32'(match_count), 32'd3);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/store_checker.md
Name: store_checker

Overview:
- Self-checking monitor for the processor data-memory write port (MemWrite/DataAdr/WriteData).
- A bench or test harness preloads an ordered list of expected stores, then arms the block.
- While armed, it compares each observed store against the list in order and reports PASS or FAIL (mismatch or timeout).
- Sits beside the top-level core so a simulation can end on a hardware verdict instead of waveform inspection.

Parameters:
DEPTH, 8, number of expected-store entries (power of 2, >=2)
CW, 4, width of match_count; must satisfy 2^CW > DEPTH
TIMEOUT, 64, consecutive RUN cycles with no store before FAIL

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
exp_valid  in  1  push one expected entry (accepted only in IDLE and not full)
exp_adr  in  32  expected store address
exp_data  in  32  expected store data
exp_full  out  1  expected queue holds DEPTH entries
arm  in  1  start checking (sampled only in IDLE)
MemWrite  in  1  core store strobe
DataAdr  in  32  core store address
WriteData  in  32  core store data
state  out  2  0=IDLE 1=RUN 2=PASS 3=FAIL
done  out  1  state is PASS or FAIL
pass  out  1  state is PASS
timed_out  out  1  FAIL was caused by timeout
fail_adr  out  32  DataAdr captured on mismatch
fail_data  out  32  WriteData captured on mismatch
match_count  out  CW  stores matched since reset

Behaviour:
- All state is updated on the rising clk edge. All outputs are registered or decoded directly from registered state; no input-to-output combinational path.
- Reset values:
  - state=IDLE; queue empty (head, tail and count = 0); exp_full=0.
  - match_count=0; timed_out=0; fail_adr=0; fail_data=0; timer=0.
  - done=0; pass=0.
- Reset has priority over every other input, and a reset asserted mid-RUN or in PASS/FAIL discards all entries and returns to IDLE on the next edge.
- Queue: circular FIFO; head and tail pointers wrap modulo DEPTH; count runs 0..DEPTH.
- IDLE:
  - exp_valid && !exp_full pushes {exp_adr, exp_data} at tail.
  - A push while full is dropped silently; count is unchanged.
  - MemWrite is ignored.
  - arm=1 goes to RUN if count (including a push in the same cycle) is > 0; otherwise it goes to PASS.
  - timer is cleared on the arm transition.
- RUN:
  - exp_valid is ignored.
  - MemWrite=1 with DataAdr==head.adr and WriteData==head.data (full 32-bit equality):
    - pop the head and increment match_count; clear timer.
    - If this was the last entry, go to PASS on the same edge.
  - MemWrite=1 with any bit different:
    - go to FAIL; latch fail_adr=DataAdr and fail_data=WriteData; timed_out stays 0; queue is not popped.
  - MemWrite=0: timer increments.
    - When the increment would reach TIMEOUT, go to FAIL with timed_out=1; fail_adr and fail_data stay 0.
  - The timeout limit is inclusive: a MemWrite on cycle TIMEOUT of silence is still compared; FAIL occurs only after TIMEOUT store-free cycles.
- PASS and FAIL are sticky until reset; all inputs are ignored; match_count and the fail_* registers hold.
- Store latency: a store seen at edge N is reflected in state and match_count after edge N (visible in cycle N+1).
- match_count saturates at 2^CW-1 (unreachable with legal parameters).

Test Plan:
- Reset for 1 cycle, push {0x64, 7}, arm; core stores 7 to 0x64 after 3 idle cycles -> state=PASS, pass=1, match_count=1, timed_out=0.
- Push {0x60,3},{0x64,7},{0x68,9}; arm; stores 3@0x60, 7@0x64, 9@0x68 -> PASS only after the third store, match_count=3.
- Push {0x64,7}; arm; store 8@0x64 -> FAIL, fail_adr=0x64, fail_data=8, match_count=0, timed_out=0, FAIL held for 20 further cycles.
- Push one entry; arm; no MemWrite -> FAIL exactly TIMEOUT (64) cycles after arm, timed_out=1. Repeat with a store on cycle 64 -> compared and PASS.
- Push 9 entries with DEPTH=8 -> exp_full=1 after the 8th push, 9th dropped; arm plus 8 matching stores -> PASS, match_count=8. Arm with empty queue -> PASS next cycle.
- Assert reset mid-RUN after 1 of 3 matches -> next cycle state=IDLE, match_count=0, exp_full=0. Re-push and re-arm -> normal PASS.
